// File: rtl/note_player_pkg.sv
// Shared definitions for the note playback path.
// Holds the default note RAM geometry (shared with the note-write stage and the
// note RAM), the rest/silence note code, the playback FSM state type, and a helper
// that sizes the hold/gap down-counter.
package note_player_pkg;

  localparam int unsigned ADDR_W_DEF = 6;   // 64-entry note RAM
  localparam int unsigned NOTE_W_DEF = 4;   // note code width
  localparam int unsigned NOTE_REST  = 0;   // note code meaning silence

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_HOLD,
    ST_GAP
  } state_t;

  // Counter width able to hold max(a,b)-1; never narrower than one bit.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/note_timer.sv
// Loadable down-counter shared by the HOLD and GAP phases of note playback.
// Ports:
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset (count -> 0)
//   i_load       load i_load_value (has priority over i_en)
//   i_en         decrement by one, saturating at zero
//   i_load_value value loaded on i_load
//   o_zero       high while the count is zero
module note_timer #(
  parameter int unsigned W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_load_value,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/note_player.sv
// Note playback stage. Reads the note RAM from address 0 up to the write pointer
// latched at start, drives each note code to the tone generator for NOTE_TICKS
// cycles followed by GAP_TICKS silent cycles. Supports single-shot and looped
// playback; stop aborts without a done pulse. All outputs are registered.
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous, active-high
//   play           level; sampled only in IDLE, starts playback
//   stop           level; aborts playback, wins over play
//   loop           1 = restart at address 0 after the last note
//   writeDirection write pointer = number of stored notes
//   readData       RAM read data, valid one cycle after readDirection
//   readDirection  RAM read address
//   note           note code to tone generator (0 when silent)
//   playing        high in every state except IDLE
//   done           one-cycle pulse when a non-looped pass completes
module note_player
  import note_player_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned NOTE_W     = NOTE_W_DEF,
  parameter int unsigned NOTE_TICKS = 25000000,
  parameter int unsigned GAP_TICKS  = 2500000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              play,
  input  logic              stop,
  input  logic              loop,
  input  logic [ADDR_W-1:0] writeDirection,
  input  logic [NOTE_W-1:0] readData,
  output logic [ADDR_W-1:0] readDirection,
  output logic [NOTE_W-1:0] note,
  output logic              playing,
  output logic              done
);

  localparam int unsigned      TW       = timer_width(NOTE_TICKS, GAP_TICKS);
  localparam logic [TW-1:0]    NOTE_LOAD = TW'(NOTE_TICKS - 1);
  localparam logic [TW-1:0]    GAP_LOAD  = TW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam bit               HAS_GAP   = (GAP_TICKS > 0);
  localparam logic [NOTE_W-1:0] REST     = NOTE_W'(NOTE_REST);

  // Registered state and outputs
  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [NOTE_W-1:0]   r_note;
  logic [ADDR_W:0]     r_end;     // one extra bit so 0 can mean "empty"
  logic                r_playing;
  logic                r_done;

  // Next-state values
  state_t              w_state_next;
  logic [ADDR_W-1:0]   w_addr_next;
  logic [NOTE_W-1:0]   w_note_next;
  logic [ADDR_W:0]     w_end_next;
  logic                w_done_next;

  // Result of finishing one note (end of GAP, or end of HOLD with no gap)
  state_t              w_adv_state;
  logic [ADDR_W-1:0]   w_adv_addr;
  logic [ADDR_W:0]     w_adv_end;
  logic                w_adv_done;

  logic                w_last;
  logic                w_tmr_load;
  logic                w_tmr_en;
  logic [TW-1:0]       w_tmr_value;
  logic                w_tmr_zero;

  note_timer #(
    .W (TW)
  ) u_timer (
    .i_clk        (clock),
    .i_rst        (reset),
    .i_load       (w_tmr_load),
    .i_en         (w_tmr_en),
    .i_load_value (w_tmr_value),
    .o_zero       (w_tmr_zero)
  );

  assign w_last = ({1'b0, r_addr} == (r_end - 1'b1));

  // The note-finished action is needed both at GAP exit and, when there is no
  // gap, directly at HOLD exit; it is computed once here and selected below.
  always_comb begin
    w_adv_state = ST_FETCH;
    w_adv_addr  = r_addr + 1'b1;
    w_adv_end   = r_end;
    w_adv_done  = 1'b0;
    if (w_last) begin
      w_adv_addr = '0;
      if (!loop) begin
        w_adv_state = ST_IDLE;
        w_adv_done  = 1'b1;
      end else begin
        // Looping re-reads the write pointer at every wrap.
        w_adv_end = {1'b0, writeDirection};
        if (writeDirection == '0) begin
          w_adv_state = ST_IDLE;
          w_adv_done  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_note_next  = r_note;
    w_end_next   = r_end;
    w_done_next  = 1'b0;
    w_tmr_load   = 1'b0;
    w_tmr_en     = 1'b0;
    w_tmr_value  = '0;

    if ((r_state != ST_IDLE) && stop) begin
      w_state_next = ST_IDLE;
      w_addr_next  = '0;
      w_note_next  = REST;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_note_next = REST;
          if (play && !stop) begin
            w_end_next = {1'b0, writeDirection};
            if (writeDirection == '0) begin
              w_done_next = 1'b1;
            end else begin
              w_state_next = ST_FETCH;
              w_addr_next  = '0;
            end
          end
        end

        ST_FETCH: begin
          w_state_next = ST_WAIT;
        end

        ST_WAIT: begin
          w_state_next = ST_HOLD;
          w_note_next  = readData;
          w_tmr_load   = 1'b1;
          w_tmr_value  = NOTE_LOAD;
        end

        ST_HOLD: begin
          if (w_tmr_zero) begin
            w_note_next = REST;
            if (HAS_GAP) begin
              w_state_next = ST_GAP;
              w_tmr_load   = 1'b1;
              w_tmr_value  = GAP_LOAD;
            end else begin
              w_state_next = w_adv_state;
              w_addr_next  = w_adv_addr;
              w_end_next   = w_adv_end;
              w_done_next  = w_adv_done;
            end
          end else begin
            w_tmr_en = 1'b1;
          end
        end

        ST_GAP: begin
          if (w_tmr_zero) begin
            w_state_next = w_adv_state;
            w_addr_next  = w_adv_addr;
            w_end_next   = w_adv_end;
            w_done_next  = w_adv_done;
          end else begin
            w_tmr_en = 1'b1;
          end
        end

        default: begin
          w_state_next = ST_IDLE;
          w_addr_next  = '0;
          w_note_next  = REST;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_note    <= REST;
      r_end     <= '0;
      r_playing <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_addr    <= w_addr_next;
      r_note    <= w_note_next;
      r_end     <= w_end_next;
      r_playing <= (w_state_next != ST_IDLE);
      r_done    <= w_done_next;
    end
  end

  assign readDirection = r_addr;
  assign note          = r_note;
  assign playing       = r_playing;
  assign done          = r_done;

endmodule

// File: tb/tb_note_player.sv
module tb_note_player;

  localparam int unsigned AW = 6;
  localparam int unsigned NW = 4;
  localparam int unsigned NT = 4;
  localparam int unsigned GT = 2;

  logic          clock;
  logic          reset;
  logic          play;
  logic          stop;
  logic          loop;
  logic [AW-1:0] writeDirection;
  logic [NW-1:0] readData;
  logic [AW-1:0] readDirection;
  logic [NW-1:0] note;
  logic          playing;
  logic          done;

  logic [NW-1:0] ram [64];

  int checks      = 0;
  int errors      = 0;
  int playing_cnt = 0;
  int done_cnt    = 0;

  typedef struct {
    logic [3:0] n;
    logic [5:0] a;
    logic       p;
    logic       d;
  } exp_t;

  exp_t q[$];

  note_player #(
    .ADDR_W     (AW),
    .NOTE_W     (NW),
    .NOTE_TICKS (NT),
    .GAP_TICKS  (GT)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .play           (play),
    .stop           (stop),
    .loop           (loop),
    .writeDirection (writeDirection),
    .readData       (readData),
    .readDirection  (readDirection),
    .note           (note),
    .playing        (playing),
    .done           (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Note RAM with one cycle of read latency
  always @(posedge clock) readData <= ram[readDirection];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] n, input logic [5:0] a, input logic p, input logic d);
    exp_t e;
    e.n = n; e.a = a; e.p = p; e.d = d;
    q.push_back(e);
  endtask

  // One pass over n notes: 2 silent fetch cycles, the note for NT cycles, GT silent cycles.
  task automatic push_pass(input int n);
    for (int a = 0; a < n; a++) begin
      for (int i = 0; i < 2; i++) push(4'd0, 6'(a), 1'b1, 1'b0);
      for (int i = 0; i < int'(NT); i++) push(ram[a], 6'(a), 1'b1, 1'b0);
      for (int i = 0; i < int'(GT); i++) push(4'd0, 6'(a), 1'b1, 1'b0);
    end
  endtask

  task automatic push_done();
    push(4'd0, 6'd0, 1'b0, 1'b1);
  endtask

  task automatic push_idle();
    push(4'd0, 6'd0, 1'b0, 1'b0);
  endtask

  task automatic step();
    exp_t e;
    @(negedge clock);
    playing_cnt += int'(playing);
    done_cnt    += int'(done);
    check("expected_entry_available", 32'(q.size() != 0), 32'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      check("note", 32'(note), 32'(e.n));
      check("readDirection", 32'(readDirection), 32'(e.a));
      check("playing", 32'(playing), 32'(e.p));
      check("done", 32'(done), 32'(e.d));
    end
  endtask

  task automatic start();
    play = 1'b1;
    step();
    play = 1'b0;
  endtask

  task automatic drain();
    while (q.size() != 0) step();
  endtask

  task automatic load_357();
    for (int i = 0; i < 64; i++) ram[i] = 4'd0;
    ram[0] = 4'd3; ram[1] = 4'd5; ram[2] = 4'd7;
  endtask

  initial begin
    int idx;
    int n;
    reset = 1'b1; play = 1'b0; stop = 1'b0; loop = 1'b0;
    writeDirection = '0;
    load_357();

    #3;
    check("reset_note", 32'(note), 32'd0);
    check("reset_readDirection", 32'(readDirection), 32'd0);
    check("reset_playing", 32'(playing), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Single-shot pass over 3,5,7
    writeDirection = 6'd3;
    playing_cnt = 0; done_cnt = 0;
    push_pass(3); push_done(); push_idle();
    start(); drain();
    check("single_playing_cycles", 32'(playing_cnt), 32'd24);
    check("single_done_pulses", 32'(done_cnt), 32'd1);

    // Empty RAM: immediate done, never plays
    writeDirection = 6'd0;
    playing_cnt = 0; done_cnt = 0;
    push_done(); push_idle(); push_idle();
    start(); drain();
    check("empty_playing_cycles", 32'(playing_cnt), 32'd0);
    check("empty_done_pulses", 32'(done_cnt), 32'd1);

    // play held high across done restarts on the next IDLE cycle
    writeDirection = 6'd1;
    push_pass(1); push_done(); push_pass(1); push_done(); push_idle();
    play = 1'b1;
    idx = 0;
    while (q.size() != 0) begin
      step();
      if (idx == 12) play = 1'b0;
      idx++;
    end

    // Random RAM contents and lengths, single-shot
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 64; i++) ram[i] = 4'($urandom_range(0, 15));
      n = int'($urandom_range(1, 7));
      writeDirection = 6'(n);
      push_pass(n); push_done(); push_idle();
      start(); drain();
    end

    // Looping over 2 notes; loop dropped during note 5 of the third pass
    load_357();
    writeDirection = 6'd2;
    loop = 1'b1;
    done_cnt = 0;
    push_pass(2); push_pass(2); push_pass(2); push_done(); push_idle();
    start();
    idx = 1;
    while (q.size() != 0) begin
      step();
      if (idx == 43) loop = 1'b0;
      idx++;
    end
    check("loop_done_pulses", 32'(done_cnt), 32'd1);

    // Stop on the 2nd HOLD cycle of note 5, then play+stop together in IDLE
    writeDirection = 6'd3;
    done_cnt = 0;
    push_pass(3);
    while (q.size() > 12) void'(q.pop_back());
    push_idle();
    start();
    for (int i = 1; i < 12; i++) step();
    stop = 1'b1;
    step();
    play = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_idle();
      step();
    end
    play = 1'b0; stop = 1'b0;
    push_idle(); step();
    check("stop_done_pulses", 32'(done_cnt), 32'd0);

    // Async reset mid-HOLD, between clock edges
    writeDirection = 6'd3;
    push_pass(3);
    while (q.size() > 5) void'(q.pop_back());
    start();
    for (int i = 1; i < 5; i++) step();
    #2 reset = 1'b1;
    #1;
    check("async_note", 32'(note), 32'd0);
    check("async_readDirection", 32'(readDirection), 32'd0);
    check("async_playing", 32'(playing), 32'd0);
    check("async_done", 32'(done), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    q.delete();
    push_idle(); step();
    push_pass(3); push_done(); push_idle();
    start(); drain();

    // Write pointer grows mid-pass: current pass keeps 2 notes, next looped pass plays 3
    writeDirection = 6'd2;
    loop = 1'b1;
    push_pass(2); push_pass(3); push_done(); push_idle();
    start();
    idx = 1;
    while (q.size() != 0) begin
      step();
      if (idx == 3) writeDirection = 6'd3;
      if (idx == 21) loop = 1'b0;
      idx++;
    end

    // Looping with write pointer cleared: wrap re-latches 0 and ends with done
    writeDirection = 6'd1;
    loop = 1'b1;
    push_pass(1); push_done(); push_idle();
    start();
    idx = 1;
    while (q.size() != 0) begin
      step();
      if (idx == 2) writeDirection = 6'd0;
      idx++;
    end
    loop = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
